// File: rtl/spi_transaction_fsm.sv
// spi_transaction_fsm: sequences one SPI memory frame (7-bit addr, R/W, 8 data bits, MSB first)
// Latency: Moore outputs; addr_we / dm_we assert 2 clk after the last counted sclk_pos pulse.
// Backpressure: none; the SPI master owns timing, and cs_n high aborts to IDLE on the next clk.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cs_n                  conditioned chip select (1 = deselected)
//   sclk_pos / sclk_neg   single-cycle pulses for rising / falling SCLK edges
//   rw_bit                shift-register bit 0, the R/W flag once the address phase is in
//   sr_load               shift-register parallel load from memory data out
//   addr_we               address-latch write enable
//   dm_we                 data-memory write enable
//   miso_en               MISO tri-state buffer enable
//   abort_pulse           (only with SPI_ABORT_FLAG_EN) one-cycle flag when a frame is cut short
//
// Optional feature macro: SPI_ABORT_FLAG_EN
module spi_transaction_fsm #(
  parameter int ADDRBITS   = 8,
  parameter int DATABITS   = 8,
  parameter int COUNTWIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic sr_load,
  output logic addr_we,
  output logic dm_we,
  output logic miso_en
`ifdef SPI_ABORT_FLAG_EN
  ,
  output logic abort_pulse
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    ADDR_LATCH,
    READ_LOAD,
    READ_SHIFT,
    WRITE_RECV,
    WRITE_COMMIT,
    DONE
  } state_t;

  localparam logic [COUNTWIDTH-1:0] ADDR_END = COUNTWIDTH'(ADDRBITS);
  localparam logic [COUNTWIDTH-1:0] DATA_END = COUNTWIDTH'(DATABITS);
  localparam logic [COUNTWIDTH-1:0] ONE      = COUNTWIDTH'(1);

  state_t                state;
  state_t                state_next;
  logic [COUNTWIDTH-1:0] count;
  logic [COUNTWIDTH-1:0] count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // The counter stops incrementing once it reaches its phase end because the
  // state leaves that phase on the following cycle, so it never exceeds the
  // larger of the two phase lengths.
  always_comb begin
    state_next = state;
    count_next = count;
    if (state != IDLE && cs_n) begin
      // Deselect wins over any edge pulse in the same cycle.
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_n) begin
            state_next = GET_ADDR;
            count_next = '0;
          end
        end
        GET_ADDR: begin
          if (count == ADDR_END) begin
            state_next = ADDR_LATCH;
          end else if (sclk_pos) begin
            count_next = count + ONE;
          end
        end
        ADDR_LATCH: begin
          count_next = '0;
          state_next = rw_bit ? READ_LOAD : WRITE_RECV;
        end
        READ_LOAD: begin
          // Memory output is valid one cycle after addr_we, so load here.
          state_next = READ_SHIFT;
        end
        READ_SHIFT: begin
          if (count == DATA_END) begin
            state_next = DONE;
          end else if (sclk_neg) begin
            count_next = count + ONE;
          end
        end
        WRITE_RECV: begin
          if (count == DATA_END) begin
            state_next = WRITE_COMMIT;
          end else if (sclk_pos) begin
            count_next = count + ONE;
          end
        end
        WRITE_COMMIT: begin
          state_next = DONE;
        end
        DONE: begin
          // Hold until deselect (handled above); extra edges never start a new frame.
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  assign addr_we = (state == ADDR_LATCH);
  assign sr_load = (state == READ_LOAD);
  assign miso_en = (state == READ_SHIFT);
  assign dm_we   = (state == WRITE_COMMIT);

`ifdef SPI_ABORT_FLAG_EN
  // Registered so it lines up with the cycle the FSM lands in IDLE after an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= cs_n && (state != IDLE) && (state != DONE);
    end
  end
`endif

endmodule
